// File: rtl/bist_tpg.sv
// Galois-LFSR test pattern generator: emits num_patterns pseudo-random words per run,
// each qualified by pattern_valid, which also serves as the MISR enable.
module bist_tpg #(
    parameter int unsigned        WIDTH        = 4,
    parameter logic [WIDTH-1:0]   POLY         = 4'b0011,
    parameter logic [WIDTH-1:0]   DEFAULT_SEED = 4'b0001,
    parameter int unsigned        COUNT_W      = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   seed,
    input  logic [COUNT_W-1:0] num_patterns,
    input  logic               hold,
    input  logic               abort,
    output logic [WIDTH-1:0]   pattern,
    output logic               pattern_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pattern_q, pattern_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0]   lfsr_next;

    assign lfsr_next = {pattern_q[WIDTH-2:0], 1'b0} ^ (pattern_q[WIDTH-1] ? POLY : '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pattern_q   <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        remaining_d = remaining_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pattern_d   = (seed == '0) ? DEFAULT_SEED : seed;
                    remaining_d = num_patterns;
                    state_d     = (num_patterns != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // A word presented with hold low is consumed even when abort lands on the same
                // edge, so the register always holds the next unconsumed LFSR state.
                if (!hold) begin
                    pattern_d   = lfsr_next;
                    remaining_d = remaining_q - 1'b1;
                end
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!hold && remaining_q == COUNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pattern       = pattern_q;
    assign busy          = (state_q != S_IDLE);
    assign pattern_valid = (state_q == S_RUN) && !hold;
    assign done          = (state_q == S_DONE) && !abort;

endmodule

// File: tb/tb_bist_tpg.sv
// Scoreboard bench for bist_tpg: the driver pushes expected words/done pulses with
// cycle stamps, an independent negedge monitor pops and compares them.
module tb_bist_tpg;

    localparam logic [3:0] POLY  = 4'b0011;
    localparam logic [3:0] DSEED = 4'b0001;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       hold  = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] seed  = '0;
    logic [7:0] num_patterns = '0;
    logic [3:0] pattern;
    logic       pattern_valid;
    logic       busy;
    logic       done;

    bist_tpg #(
        .WIDTH       (4),
        .POLY        (POLY),
        .DEFAULT_SEED(DSEED),
        .COUNT_W     (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .seed         (seed),
        .num_patterns (num_patterns),
        .hold         (hold),
        .abort        (abort),
        .pattern      (pattern),
        .pattern_valid(pattern_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] pat;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: multiply by x in GF(2)[x] modulo x^4 + POLY
    function automatic logic [3:0] mulx(input logic [3:0] v);
        int t;
        t = int'(v) * 2;
        if (t >= 16) t = t ^ (16 | int'(POLY));
        return t[3:0];
    endfunction

    exp_t mon_e;
    int   mon_d;
    always @(negedge clock) begin
        if (reset) begin
            if (pattern_valid) begin
                check("busy_while_valid", {31'd0, busy}, 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, pattern_valid}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("valid_cycle", cyc, mon_e.cyc);
                    check("pattern", {28'd0, pattern}, {28'd0, mon_e.pat});
                end
            end
            if (done) begin
                check("busy_while_done", {31'd0, busy}, 32'd1);
                if (done_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", cyc, mon_d);
                end
            end
        end
    end

    task automatic run(input logic [3:0] s, input int n, input int hold_mode, input int abort_k,
                       input bit abort_hold, input bit abort_in_done, input bit abort_with_start);
        logic [3:0] seq[$];
        int  consumed = 0;
        int  hcnt = 0;
        bit  aborted = 1'b0;
        bit  h;
        seq.push_back((s == 4'd0) ? DSEED : s);
        for (int i = 0; i < n; i++) seq.push_back(mulx(seq[i]));

        @(posedge clock); #1;
        start = 1'b1; seed = s; num_patterns = n[7:0]; abort = abort_with_start;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0; seed = 4'($urandom); num_patterns = 8'($urandom);

        while (consumed < n && !aborted) begin
            h = 1'b0;
            if (abort_k > 0 && consumed == abort_k && abort_hold) begin
                hold = 1'b1; abort = 1'b1; aborted = 1'b1;
            end else begin
                case (hold_mode)
                    1: h = ($urandom_range(0, 9) < 3);
                    2: if (consumed == 2 && hcnt < 3) begin h = 1'b1; hcnt++; end
                    default: h = 1'b0;
                endcase
                hold = h;
                if (!h) begin
                    exp_q.push_back('{seq[consumed], cyc});
                    consumed++;
                    if (abort_k > 0 && consumed == abort_k && !abort_hold) begin
                        abort = 1'b1; aborted = 1'b1;
                    end
                end
                if (hold_mode == 1 && $urandom_range(0, 9) == 0) start = 1'b1;
            end
            @(posedge clock); #1;
            hold = 1'b0; abort = 1'b0; start = 1'b0;
        end

        if (!aborted) begin
            if (abort_in_done) abort = 1'b1;
            else done_q.push_back(cyc);
            if ($urandom_range(0, 1) == 1) start = 1'b1;
            @(posedge clock); #1;
            abort = 1'b0; start = 1'b0;
        end

        check("busy_after_run", {31'd0, busy}, 32'd0);
        check("valid_after_run", {31'd0, pattern_valid}, 32'd0);
        check("done_after_run", {31'd0, done}, 32'd0);
        check("pattern_after_run", {28'd0, pattern}, {28'd0, seq[consumed]});
        check("pending_valids", exp_q.size(), 32'd0);
        check("pending_done", done_q.size(), 32'd0);
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic reset_mid_run();
        logic [3:0] v;
        v = 4'd1;
        @(posedge clock); #1;
        start = 1'b1; seed = 4'd1; num_patterns = 8'd10;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{v, cyc});
            v = mulx(v);
            @(posedge clock); #1;
        end
        #2 reset = 1'b0;
        #1;
        check("rst_async_pattern", {28'd0, pattern}, 32'd0);
        check("rst_async_valid", {31'd0, pattern_valid}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_done", {31'd0, done}, 32'd0);
        check("rst_pending_valids", exp_q.size(), 32'd0);
        exp_q.delete();
        #13 reset = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_pattern", {28'd0, pattern}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_pattern", {28'd0, pattern}, 32'd0);
        check("reset_valid", {31'd0, pattern_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        #11 reset = 1'b1;

        run(4'd1, 5, 0, 0, 1'b0, 1'b0, 1'b0);
        run(4'd1, 16, 0, 0, 1'b0, 1'b0, 1'b0);
        run(4'd1, 5, 2, 0, 1'b0, 1'b0, 1'b0);
        run(4'd0, 2, 0, 0, 1'b0, 1'b0, 1'b0);
        run(4'd1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run(4'd1, 10, 1, 0, 1'b0, 1'b0, 1'b0);
        run(4'd1, 10, 0, 3, 1'b0, 1'b0, 1'b0);
        run(4'd5, 10, 0, 3, 1'b1, 1'b0, 1'b0);
        run(4'd6, 4, 0, 4, 1'b0, 1'b0, 1'b0);
        run(4'd3, 4, 0, 0, 1'b0, 1'b1, 1'b0);
        run(4'd7, 3, 0, 0, 1'b0, 1'b0, 1'b1);
        run(4'd9, 255, 1, 0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            int n;
            int ak;
            bit ah;
            n  = $urandom_range(0, 40);
            ak = 0;
            ah = 1'b0;
            if (n > 1 && $urandom_range(0, 3) == 0) begin
                ah = $urandom_range(0, 1) == 1;
                ak = ah ? $urandom_range(1, n - 1) : $urandom_range(1, n);
            end
            run(4'($urandom), n, $urandom_range(0, 1), ak, ah,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
        end

        reset_mid_run();
        run(4'd0, 3, 1, 0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
